stopwatch_ctrl: RTL

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl
// Brief    : Two-button stopwatch controller. Synchronises and debounces the
//            start/stop and lap/reset buttons, runs the IDLE/RUN/PAUSE/LAP
//            state machine and a tick prescaler that drives the time counter.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
    parameter int TICK_DIV   = 100,
    parameter int DEB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       lap_reset,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       disp_hold,
    output logic [1:0] state
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_LAP   = 2'b11;

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DEB_CYCLES + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);

    // Bit 0 is start_stop, bit 1 is lap_reset throughout the button logic.
    logic [1:0]    btn_raw;
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    prime_q;
    logic [1:0]    level_q;
    logic [1:0]    level_prev_q;
    logic [1:0]    armed_q;
    logic [1:0]    press_q;
    logic [DW-1:0] deb_cnt_q [2];
    logic [DW-1:0] arm_cnt_q [2];

    logic          ss_ev;
    logic          lr_ev;

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic          clr_d;
    logic          hold_d;
    logic          en_d;
    logic          cnt_clr_q;
    logic          disp_hold_q;
    logic          cnt_en_q;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    assign btn_raw = {lap_reset, start_stop};
    assign ss_ev   = press_q[0];
    assign lr_ev   = press_q[1];

    // Button front end: 2-FF synchroniser, stability-count debouncer, press
    // edge detector. A button is only "armed" once it has been seen settled
    // low after reset, so a button held through reset needs a fresh press.
    // prime_q marks when the synchroniser output reflects the real pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            prime_q      <= '0;
            level_q      <= '0;
            level_prev_q <= '0;
            armed_q      <= '0;
            press_q      <= '0;
            for (int b = 0; b < 2; b++) begin
                deb_cnt_q[b] <= '0;
                arm_cnt_q[b] <= '0;
            end
        end else begin
            sync1_q      <= btn_raw;
            sync2_q      <= sync1_q;
            prime_q      <= {prime_q[0], 1'b1};
            level_prev_q <= level_q;
            for (int b = 0; b < 2; b++) begin
                if (sync2_q[b] != level_q[b]) begin
                    if (deb_cnt_q[b] == DEB_LAST) begin
                        level_q[b]   <= ~level_q[b];
                        deb_cnt_q[b] <= '0;
                    end else begin
                        deb_cnt_q[b] <= deb_cnt_q[b] + 1'b1;
                    end
                end else begin
                    deb_cnt_q[b] <= '0;
                end

                if (!armed_q[b]) begin
                    if (prime_q[1] && !sync2_q[b] && !level_q[b]) begin
                        if (arm_cnt_q[b] == DEB_LAST) begin
                            armed_q[b] <= 1'b1;
                        end else begin
                            arm_cnt_q[b] <= arm_cnt_q[b] + 1'b1;
                        end
                    end else begin
                        arm_cnt_q[b] <= '0;
                    end
                end

                press_q[b] <= armed_q[b] & level_q[b] & ~level_prev_q[b];
            end
        end
    end

    // State register plus the registered outputs that accompany each state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_clr_q   <= 1'b0;
            disp_hold_q <= 1'b0;
            cnt_en_q    <= 1'b0;
            presc_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_clr_q   <= clr_d;
            disp_hold_q <= hold_d;
            cnt_en_q    <= en_d;
            presc_q     <= presc_d;
        end
    end

    // Next-state logic; start_stop takes priority over a coincident lap_reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (ss_ev) state_d = S_RUN;
            end
            S_RUN: begin
                if (ss_ev)      state_d = S_PAUSE;
                else if (lr_ev) state_d = S_LAP;
            end
            S_LAP: begin
                if (ss_ev)      state_d = S_PAUSE;
                else if (lr_ev) state_d = S_RUN;
            end
            S_PAUSE: begin
                if (ss_ev)      state_d = S_RUN;
                else if (lr_ev) state_d = S_IDLE;
            end
        endcase
    end

    // Output/prescaler logic keyed on the upcoming state, so a tick pulse
    // always lands in a RUN/LAP cycle and pause keeps the partial count.
    always_comb begin
        clr_d   = 1'b0;
        en_d    = 1'b0;
        presc_d = presc_q;
        if (lr_ev && !ss_ev && (state_q == S_IDLE || state_q == S_PAUSE)) begin
            clr_d = 1'b1;
        end
        hold_d = (state_d == S_LAP);
        case (state_d)
            S_RUN, S_LAP: begin
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    en_d    = 1'b1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            S_PAUSE: presc_d = presc_q;
            default: presc_d = '0;
        endcase
        if (clr_d) begin
            en_d = 1'b0;
        end
    end

    assign state     = state_q;
    assign cnt_clr   = cnt_clr_q;
    assign disp_hold = disp_hold_q;
    assign cnt_en    = cnt_en_q;

endmodule
`default_nettype wire
